lzc_share_arb: RTL

- Shares one 16-bit leading-zero counter (lzc_miao_16 instance) between NUM_REQ requesters in the AV1 arithmetic encoder, e.g. range renormalization lanes.
- Provides round-robin arbitration, a 2-stage registered pipeline and valid/ready handshakes on both sides.
- Returns one tagged result per accepted request, in grant order, at up to one result per cycle.

---
 rtl/lzc_share_arb.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/lzc_share_arb.sv
// Shared 16-bit leading-zero counter with a registered 2-stage pipeline and an arbiter.
// Define LZC_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.

module lzc_miao_16 (
  input  logic [15:0] data,
  output logic [3:0]  cnt,
  output logic        v
);

  logic [3:0] nib [4];
  logic [3:0] nv;
  logic [1:0] hi;
  logic [1:0] lo;
  logic [1:0] sel;

  // 4-bit priority encode, reused for nibble flags and the chosen nibble
  function automatic logic [1:0] enc4(input logic [3:0] b);
    return {~b[3] & ~b[2], ~b[3] & (b[2] | ~b[1])};
  endfunction

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      nib[k] = data[k*4 +: 4];
      nv[k]  = |data[k*4 +: 4];
    end
    hi  = enc4(nv);
    sel = 2'd3 - hi;
    lo  = enc4(nib[sel]);
    cnt = {hi, lo};
    v   = |nv;
  end

endmodule

module lzc_share_arb #(
  parameter int RANGE_WIDTH = 16,
  parameter int D_SIZE      = 4,
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*RANGE_WIDTH-1:0] req_data,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [ID_W-1:0]              resp_id,
  output logic [D_SIZE-1:0]            resp_lzc,
  output logic                         resp_zero
);

  typedef struct packed {
    logic [RANGE_WIDTH-1:0] opnd;
    logic [ID_W-1:0]        id;
  } s1_t;

  logic [RANGE_WIDTH-1:0] opnd [NUM_REQ];
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        cand;
  logic [ID_W-1:0]        gnt;
  logic                   gnt_found;
  logic                   xfer;
  logic                   s1_valid;
  s1_t                    s1_q;
  logic                   s2_adv;
  logic                   s1_adv;
  logic                   s1_free;
  logic [3:0]             lzc_cnt;
  logic                   lzc_v;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign opnd[i] = req_data[i*RANGE_WIDTH +: RANGE_WIDTH];
  end

  // explicit wrap so non power-of-two NUM_REQ never overruns
  function automatic logic [ID_W-1:0] wrap_add(
    input logic [ID_W-1:0] a,
    input int              k
  );
    int s;
    s = int'(a) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[ID_W-1:0];
  endfunction

  assign s2_adv  = !resp_valid | resp_ready;
  assign s1_adv  = s1_valid & s2_adv;
  assign s1_free = !s1_valid | s2_adv;

  always_comb begin
    gnt_found = 1'b0;
    gnt       = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = wrap_add(rr_ptr, k);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt       = cand;
      end
    end
  end

  assign xfer = gnt_found & s1_free & reset_n;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[gnt] = 1'b1;
  end

`ifdef LZC_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= wrap_add(gnt, 1);
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (xfer) begin
      s1_valid <= 1'b1;
      s1_q     <= '{opnd: opnd[gnt], id: gnt};
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  lzc_miao_16 u_lzc (
    .data (s1_q.opnd),
    .cnt  (lzc_cnt),
    .v    (lzc_v)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_lzc   <= '0;
      resp_zero  <= 1'b0;
    end else if (s1_adv) begin
      resp_valid <= 1'b1;
      resp_id    <= s1_q.id;
      resp_lzc   <= lzc_v ? D_SIZE'(lzc_cnt) : '0;
      resp_zero  <= !lzc_v;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule
